// File: rtl/gen2_cmd_rx_if.sv
// Bit-decoder to command-receiver bus: decoded bit stream in, classified command out.
interface gen2_cmd_rx_if;
  logic       frame_start;
  logic       bit_valid;
  logic       bit_in;
  logic       busy;
  logic       query_valid;
  logic       crc_err;
  logic       qrep_valid;
  logic       qadj_valid;
  logic       unknown_cmd;
  logic       dr;
  logic       trext;
  logic       target;
  logic [1:0] m;
  logic [1:0] sel;
  logic [1:0] session;
  logic [3:0] q;
  logic [2:0] updn;
  logic [4:0] crc;

  modport master (
    output frame_start, bit_valid, bit_in,
    input  busy, query_valid, crc_err, qrep_valid, qadj_valid, unknown_cmd,
    input  dr, trext, target, m, sel, session, q, updn, crc
  );

  modport slave (
    input  frame_start, bit_valid, bit_in,
    output busy, query_valid, crc_err, qrep_valid, qadj_valid, unknown_cmd,
    output dr, trext, target, m, sel, session, q, updn, crc
  );
endinterface

// File: rtl/gen2_cmd_rx.sv
// Tag-side bit-serial receiver for Query / QueryRep / QueryAdjust with in-line CRC5.
module gen2_cmd_rx #(
  parameter logic [4:0] CRC_PRESET  = 5'b01001,
  parameter logic [4:0] CRC_RESIDUE = 5'b00000
) (
  input  logic         clk,
  input  logic         reset_n,
  gen2_cmd_rx_if.slave bus
);

  localparam int unsigned CNT_W    = 5;
  localparam int unsigned SHADOW_W = 13;
  localparam logic [CNT_W-1:0] CNT_OP2      = 5'd1;
  localparam logic [CNT_W-1:0] CNT_OP4      = 5'd3;
  localparam logic [CNT_W-1:0] CNT_QREP     = 5'd3;
  localparam logic [CNT_W-1:0] CNT_QADJ     = 5'd8;
  localparam logic [CNT_W-1:0] CNT_QDATA    = 5'd17;
  localparam logic [CNT_W-1:0] CNT_QUERY    = 5'd21;

  // One CRC5 shift, polynomial x^5+x^3+1
  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
    logic f;
    f = b ^ c[4];
    return {c[3], c[2] ^ f, c[1], c[0], f};
  endfunction

  // The opcode is only known to be Query after 4 bits, so its CRC contribution is applied at once
  localparam logic [4:0] CRC_AFTER_OP =
    crc5_step(crc5_step(crc5_step(crc5_step(CRC_PRESET, 1'b1), 1'b0), 1'b0), 1'b0);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_QUERY, S_QREP, S_QADJ, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4:0]          crc_q, crc_d;
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic [SHADOW_W-1:0] shift_c;
  logic busy_q, busy_d;
  logic query_valid_q, query_valid_d;
  logic crc_err_q, crc_err_d;
  logic qrep_valid_q, qrep_valid_d;
  logic qadj_valid_q, qadj_valid_d;
  logic unknown_cmd_q, unknown_cmd_d;
  logic dr_q, dr_d, trext_q, trext_d, target_q, target_d;
  logic [1:0] m_q, m_d, sel_q, sel_d, session_q, session_d;
  logic [3:0] q_q, q_d;
  logic [2:0] updn_q, updn_d;

  assign shift_c = {shadow_q[SHADOW_W-2:0], bus.bit_in};

  // Next-state, field capture and result pulses
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    crc_d         = crc_q;
    shadow_d      = shadow_q;
    query_valid_d = 1'b0;
    crc_err_d     = 1'b0;
    qrep_valid_d  = 1'b0;
    qadj_valid_d  = 1'b0;
    unknown_cmd_d = 1'b0;
    dr_d          = dr_q;
    trext_d       = trext_q;
    target_d      = target_q;
    m_d           = m_q;
    sel_d         = sel_q;
    session_d     = session_q;
    q_d           = q_q;
    updn_d        = updn_q;

    if (bus.frame_start) begin
      state_d = S_CMD;
      cnt_d   = '0;
      crc_d   = CRC_PRESET;
    end else if (bus.bit_valid) begin
      case (state_q)
        S_CMD: begin
          cnt_d    = cnt_q + 5'd1;
          shadow_d = shift_c;
          if (cnt_q == CNT_OP2) begin
            if (shift_c[1:0] == 2'b00) begin
              state_d = S_QREP;
            end else if (shift_c[1:0] != 2'b10) begin
              unknown_cmd_d = 1'b1;
              state_d       = S_DONE;
            end
          end else if (cnt_q == CNT_OP4) begin
            case (shift_c[1:0])
              2'b00: begin
                state_d = S_QUERY;
                crc_d   = CRC_AFTER_OP;
              end
              2'b01: state_d = S_QADJ;
              default: begin
                unknown_cmd_d = 1'b1;
                state_d       = S_DONE;
              end
            endcase
          end
        end
        S_QUERY: begin
          cnt_d = cnt_q + 5'd1;
          crc_d = crc5_step(crc_q, bus.bit_in);
          if (cnt_q < CNT_QDATA) begin
            shadow_d = shift_c;
          end
          if (cnt_q == CNT_QUERY) begin
            state_d = S_DONE;
            if (crc_d == CRC_RESIDUE) begin
              query_valid_d = 1'b1;
              dr_d          = shadow_q[12];
              m_d           = shadow_q[11:10];
              trext_d       = shadow_q[9];
              sel_d         = shadow_q[8:7];
              session_d     = shadow_q[6:5];
              target_d      = shadow_q[4];
              q_d           = shadow_q[3:0];
            end else begin
              crc_err_d = 1'b1;
            end
          end
        end
        S_QREP: begin
          cnt_d    = cnt_q + 5'd1;
          shadow_d = shift_c;
          if (cnt_q == CNT_QREP) begin
            qrep_valid_d = 1'b1;
            session_d    = shift_c[1:0];
            state_d      = S_DONE;
          end
        end
        S_QADJ: begin
          cnt_d    = cnt_q + 5'd1;
          shadow_d = shift_c;
          if (cnt_q == CNT_QADJ) begin
            qadj_valid_d = 1'b1;
            session_d    = shift_c[4:3];
            updn_d       = shift_c[2:0];
            state_d      = S_DONE;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == S_CMD) || (state_d == S_QUERY) ||
             (state_d == S_QREP) || (state_d == S_QADJ);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      crc_q         <= CRC_PRESET;
      shadow_q      <= '0;
      busy_q        <= 1'b0;
      query_valid_q <= 1'b0;
      crc_err_q     <= 1'b0;
      qrep_valid_q  <= 1'b0;
      qadj_valid_q  <= 1'b0;
      unknown_cmd_q <= 1'b0;
      dr_q          <= 1'b0;
      trext_q       <= 1'b0;
      target_q      <= 1'b0;
      m_q           <= '0;
      sel_q         <= '0;
      session_q     <= '0;
      q_q           <= '0;
      updn_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      crc_q         <= crc_d;
      shadow_q      <= shadow_d;
      busy_q        <= busy_d;
      query_valid_q <= query_valid_d;
      crc_err_q     <= crc_err_d;
      qrep_valid_q  <= qrep_valid_d;
      qadj_valid_q  <= qadj_valid_d;
      unknown_cmd_q <= unknown_cmd_d;
      dr_q          <= dr_d;
      trext_q       <= trext_d;
      target_q      <= target_d;
      m_q           <= m_d;
      sel_q         <= sel_d;
      session_q     <= session_d;
      q_q           <= q_d;
      updn_q        <= updn_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.query_valid = query_valid_q;
  assign bus.crc_err     = crc_err_q;
  assign bus.qrep_valid  = qrep_valid_q;
  assign bus.qadj_valid  = qadj_valid_q;
  assign bus.unknown_cmd = unknown_cmd_q;
  assign bus.dr          = dr_q;
  assign bus.trext       = trext_q;
  assign bus.target      = target_q;
  assign bus.m           = m_q;
  assign bus.sel         = sel_q;
  assign bus.session     = session_q;
  assign bus.q           = q_q;
  assign bus.updn        = updn_q;
  assign bus.crc         = crc_q;

endmodule

// File: tb/tb_gen2_cmd_rx.sv
// Scoreboard bench for gen2_cmd_rx: frames modelled as bit strings, CRC by polynomial division.
module tb_gen2_cmd_rx;

  localparam logic [4:0] PRESET = 5'b01001;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  gen2_cmd_rx_if bus();

  gen2_cmd_rx dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // kind: 0 query_valid, 1 crc_err, 2 qrep_valid, 3 qadj_valid, 4 unknown_cmd
  typedef struct {
    int          kind;
    logic [15:0] fields;
    logic [4:0]  crc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference view of the command fields held by the tag
  logic       md, mtr, mtgt;
  logic [1:0] mm, msel, msess;
  logic [3:0] mq;
  logic [2:0] mupdn;

  function automatic logic [15:0] model_fields();
    return {md, mm, mtr, msel, msess, mtgt, mq, mupdn};
  endfunction

  function automatic logic [15:0] dut_fields();
    return {bus.dr, bus.m, bus.trext, bus.sel, bus.session, bus.target, bus.q, bus.updn};
  endfunction

  task automatic model_reset();
    md = 0; mtr = 0; mtgt = 0; mm = 0; msel = 0; msess = 0; mq = 0; mupdn = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register after n message bits = (x^5*M(x) + x^n*P(x)) mod (x^5+x^3+1)
  function automatic logic [4:0] rem5(input logic [31:0] msg, input int n);
    logic [63:0] v;
    v = (64'(msg) << 5) ^ (64'(PRESET) << n);
    for (int i = 63; i >= 5; i--) begin
      if (((v >> i) & 64'd1) != 64'd0) v = v ^ (64'h29 << (i - 5));
    end
    return v[4:0];
  endfunction

  function automatic logic bit_at(input logic [31:0] msg, input int n, input int k);
    logic [31:0] s;
    s = msg >> (n - 1 - k);
    return s[0];
  endfunction

  // Classify a frame of n bits (first bit = msg[n-1]); push the expected outcome if it completes
  task automatic expect_frame(input logic [31:0] msg, input int n);
    exp_t        e;
    int          kind;
    logic [21:0] f;
    logic [8:0]  f9;
    logic [4:0]  r;
    kind = -1;
    r    = PRESET;
    if (n >= 2) begin
      if (bit_at(msg, n, 0) == 1'b0 && bit_at(msg, n, 1) == 1'b0) begin
        if (n >= 4) begin
          kind  = 2;
          msess = {bit_at(msg, n, 2), bit_at(msg, n, 3)};
        end
      end else if (!(bit_at(msg, n, 0) == 1'b1 && bit_at(msg, n, 1) == 1'b0)) begin
        kind = 4;
      end else if (n >= 4) begin
        if (bit_at(msg, n, 2) == 1'b0 && bit_at(msg, n, 3) == 1'b0) begin
          if (n >= 22) begin
            f = 22'(msg >> (n - 22));
            r = rem5(32'(f), 22);
            if (r == 5'd0) begin
              kind = 0;
              md = f[17]; mm = f[16:15]; mtr = f[14]; msel = f[13:12];
              msess = f[11:10]; mtgt = f[9]; mq = f[8:5];
            end else begin
              kind = 1;
            end
          end
        end else if (bit_at(msg, n, 2) == 1'b0 && bit_at(msg, n, 3) == 1'b1) begin
          if (n >= 9) begin
            kind  = 3;
            f9    = 9'(msg >> (n - 9));
            msess = f9[4:3];
            mupdn = f9[2:0];
          end
        end else begin
          kind = 4;
        end
      end
    end
    if (kind >= 0) begin
      e.kind   = kind;
      e.fields = model_fields();
      e.crc    = (kind <= 1) ? r : PRESET;
      exp_q.push_back(e);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    repeat ($urandom_range(0, 2)) cycle();
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    cycle();
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'($urandom);
  endtask

  task automatic send_frame(input logic [31:0] msg, input int n);
    bus.frame_start = 1'b1;
    bus.bit_valid   = 1'($urandom);
    bus.bit_in      = 1'($urandom);
    cycle();
    bus.frame_start = 1'b0;
    bus.bit_valid   = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    for (int k = 0; k < n; k++) send_bit(bit_at(msg, n, k));
  endtask

  task automatic do_frame(input logic [31:0] msg, input int n);
    expect_frame(msg, n);
    send_frame(msg, n);
    repeat (2) cycle();
  endtask

  function automatic logic [31:0] make_query(input logic [12:0] d);
    logic [16:0] data;
    data = {4'b1000, d};
    return {10'd0, data, rem5(32'(data), 17)};
  endfunction

  // Monitor: every result pulse must match the oldest expected outcome
  always @(negedge clk) begin
    logic [4:0] pv;
    exp_t       e;
    if (reset_n === 1'b1) begin
      pv = {bus.query_valid, bus.crc_err, bus.qrep_valid, bus.qadj_valid, bus.unknown_cmd};
      if (pv != 5'd0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'(pv), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", 32'(pv), 32'(5'b10000 >> e.kind));
          check("fields", 32'(dut_fields()), 32'(e.fields));
          check("crc_at_pulse", 32'(bus.crc), 32'(e.crc));
          check("busy_at_pulse", 32'(bus.busy), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [31:0] msg;
    int          n;
    int          e;
    bus.frame_start = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.bit_in      = 1'b0;
    reset_n         = 1'b0;
    model_reset();
    repeat (3) cycle();
    reset_n = 1'b1;
    cycle();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_crc", 32'(bus.crc), 32'(PRESET));
    check("reset_fields", 32'(dut_fields()), 32'd0);
    check("reset_pulses", 32'({bus.query_valid, bus.crc_err, bus.qrep_valid,
                               bus.qadj_valid, bus.unknown_cmd}), 32'd0);

    // Directed frames
    do_frame(32'b1000000000000000010000, 22);
    do_frame(32'b1000000000000000010001, 22);
    do_frame(32'b0010, 4);
    do_frame(32'b100101110, 9);
    do_frame(32'b1000000000, 10);
    do_frame(32'b0001, 4);
    do_frame(32'b11010, 5);

    // Reset after 15 Query bits, then the rest of the frame without a new frame_start
    msg = make_query(13'h0a5);
    send_frame(msg >> 7, 15);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    model_reset();
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_crc", 32'(bus.crc), 32'(PRESET));
    check("midreset_fields", 32'(dut_fields()), 32'd0);
    for (int k = 15; k < 22; k++) send_bit(bit_at(msg, 22, k));
    repeat (2) cycle();
    check("after_reset_busy", 32'(bus.busy), 32'd0);
    check("after_reset_crc", 32'(bus.crc), 32'(PRESET));

    // Randomized frames
    for (int it = 0; it < 160; it++) begin
      case ($urandom_range(0, 6))
        0, 1: begin msg = make_query(13'($urandom)); n = 22; end
        2: begin
          msg = make_query(13'($urandom)) ^ (32'd1 << $urandom_range(0, 17));
          n = 22;
        end
        3: begin msg = {30'd0, 2'($urandom)}; n = 4; end
        4: begin msg = {23'd0, 4'b1001, 5'($urandom)}; n = 9; end
        5: begin
          if ($urandom_range(0, 1) == 0) begin msg = {30'd0, 1'($urandom), 1'b1}; n = 2; end
          else begin msg = {28'd0, 3'b101, 1'($urandom)}; n = 4; end
        end
        default: begin
          n   = $urandom_range(0, 21);
          msg = make_query(13'($urandom)) >> (22 - n);
        end
      endcase
      if (n >= 2 && $urandom_range(0, 2) == 0) begin
        e   = $urandom_range(1, 3);
        msg = (msg << e) | (32'($urandom) & ((32'd1 << e) - 32'd1));
        n   = n + e;
      end
      do_frame(msg, n);
    end

    repeat (5) cycle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
